load_store_unit: RTL

Memory-access stage that sits directly upstream of the data RAM, between the CPU datapath and the RAM.
- Accepts byte, halfword and word load/store requests on a valid/ready handshake.
- Converts byte addresses into the RAM's word index and drives the RAM's address, write-data and write-enable inputs.
- Sign- or zero-extends load data.
- Performs sub-word stores as a read-modify-write on the word-wide RAM.
- Flags misaligned and out-of-range accesses instead of touching memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 45 ++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size and state encodings plus byte-lane mask.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    RESP   = 2'b11
  } state_t;

  function automatic logic [3:0] lane_mask(
    input size_t      size,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (size == SZ_BYTE): m = 4'b0001 << off;
      (size == SZ_HALF): m = off[1] ? 4'b1100 : 4'b0011;
      (size == SZ_WORD): m = 4'b1111;
      default:           m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit.
// Extends load data and merges sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] sdata
);

  logic [31:0] rsh;
  logic [31:0] lsh;
  logic [3:0]  mask;
  logic        sb;
  logic        sh;

  assign rsh  = word >> {offset, 3'b000};
  assign lsh  = wdata << {offset, 3'b000};
  assign mask = lane_mask(size, offset);
  assign sb   = ~is_unsigned & rsh[7];
  assign sh   = ~is_unsigned & rsh[15];

  // Right-align the addressed lane(s) and extend.
  always_comb begin
    ldata = word;
    unique case (1'b1)
      (size == SZ_BYTE): ldata = {{24{sb}}, rsh[7:0]};
      (size == SZ_HALF): ldata = {{16{sh}}, rsh[15:0]};
      default:           ldata = word;
    endcase
  end

  // Replace enabled lanes of the old word with store data.
  always_comb begin
    sdata = word;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) sdata[8*k +: 8] = lsh[8*k +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage in front of a word-wide data RAM.
// Sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write,
  input  logic [31:0] mem_data_out
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  size_t       size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;

  size_t       req_sz;
  logic        req_err;
  logic [31:0] al_word;
  logic [31:0] al_ldata;
  logic [31:0] al_sdata;

  assign req_sz = size_t'(req_size);

  // Classify an incoming request as illegal before touching RAM.
  always_comb begin
    req_err = 1'b0;
    unique case (1'b1)
      (req_sz == SZ_ILL):  req_err = 1'b1;
      (req_sz == SZ_HALF): req_err = req_addr[0];
      (req_sz == SZ_WORD): req_err = |req_addr[1:0];
      default:             req_err = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH) req_err = 1'b1;
  end

  assign al_word = (state_q == MERGE) ? merge_q : mem_data_out;

  lsu_align u_align (
    .word        (al_word),
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .ldata       (al_ldata),
    .sdata       (al_sdata)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          size_d  = req_sz;
          uns_d   = req_unsigned;
          err_d   = req_err;
          rdata_d = 32'h0;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = al_ldata;
          state_d = RESP;
        end else if (size_q == SZ_WORD) begin
          state_d = RESP;
        end else begin
          merge_d = mem_data_out;
          state_d = MERGE;
        end
      end
      MERGE: state_d = RESP;
      RESP: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  // RAM write strobe and data, decoded from registered state.
  always_comb begin
    mem_write   = 1'b0;
    mem_data_in = 32'h0;
    unique case (1'b1)
      (state_q == ACCESS && we_q && size_q == SZ_WORD): begin
        mem_write   = 1'b1;
        mem_data_in = wdata_q;
      end
      (state_q == MERGE): begin
        mem_write   = 1'b1;
        mem_data_in = al_sdata;
      end
      default: begin
        mem_write   = 1'b0;
        mem_data_in = 32'h0;
      end
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_error   = err_q;
  assign mem_address = {2'b00, addr_q[31:2]};

endmodule
